// File: rtl/arb_rr_n.sv
// N-requester arbiter with round-robin or fixed-priority search and a bounded
// grant hold, so that a busy owner cannot starve the other requesters.
module arb_rr_n #(
   parameter  int N        = 4,
   parameter  int MAX_HOLD = 4,
   localparam int ID_W     = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    request,
   input  logic            fixed_pri,
   output logic [N-1:0]    grant,
   output logic            grant_valid,
   output logic [ID_W-1:0] grant_id
);

   localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
   localparam logic [ID_W-1:0]   ID_LAST   = ID_W'(N - 1);

   logic [ID_W-1:0]   ptr_r;
   logic [ID_W-1:0]   ptr_s;
   logic [HOLD_W-1:0] hold_cnt_r;
   logic [HOLD_W-1:0] hold_cnt_s;
   logic [N-1:0]      grant_s;
   logic              grant_valid_s;
   logic [ID_W-1:0]   grant_id_s;
   logic [N-1:0]      owner_bit_s;
   logic [N-1:0]      mask_s;
   logic [ID_W-1:0]   start_s;
   logic [ID_W-1:0]   next_ptr_s;
   logic              arbitrate_s;
   logic              found_s;
   logic [ID_W-1:0]   pick_id_s;

   // First set bit of mask scanning upward from start with modulo-N wrap; MSB = found.
   function automatic logic [ID_W:0] pick(input logic [ID_W-1:0] start, input logic [N-1:0] mask);
      logic            found;
      logic [ID_W-1:0] idx;
      int              k;
      found = 1'b0;
      idx   = '0;
      for (int j = 0; j < N; j++) begin
         k = (int'(start) + j) % N;
         if (!found && mask[k]) begin
            found = 1'b1;
            idx   = ID_W'(k);
         end
      end
      return {found, idx};
   endfunction

   function automatic logic [N-1:0] onehot(input logic [ID_W-1:0] idx);
      return N'(1) << idx;
   endfunction

   // Next-state decision: hold, release, preempt, or arbitrate from IDLE.
   always_comb begin
      owner_bit_s   = onehot(grant_id);
      next_ptr_s    = (grant_id == ID_LAST) ? '0 : grant_id + ID_W'(1);
      ptr_s         = ptr_r;
      hold_cnt_s    = hold_cnt_r;
      grant_s       = grant;
      grant_valid_s = grant_valid;
      grant_id_s    = grant_id;
      start_s       = ptr_r;
      mask_s        = '0;
      arbitrate_s   = 1'b0;

      if (!grant_valid) begin
         arbitrate_s = 1'b1;
         mask_s      = request;
         start_s     = fixed_pri ? '0 : ptr_r;
      end else if (!request[grant_id]) begin
         arbitrate_s = 1'b1;
         ptr_s       = next_ptr_s;
         mask_s      = request;
         start_s     = fixed_pri ? '0 : next_ptr_s;
      end else if (hold_cnt_r != HOLD_LAST) begin
         hold_cnt_s = hold_cnt_r + HOLD_W'(1);
      end else if ((request & ~owner_bit_s) != '0) begin
         // Burst limit reached with others waiting: the owner is excluded from this search.
         arbitrate_s = 1'b1;
         ptr_s       = next_ptr_s;
         mask_s      = request & ~owner_bit_s;
         start_s     = fixed_pri ? '0 : next_ptr_s;
      end else begin
         hold_cnt_s = HOLD_LAST;
      end

      {found_s, pick_id_s} = pick(start_s, mask_s);

      if (arbitrate_s) begin
         hold_cnt_s = '0;
         if (found_s) begin
            grant_s       = onehot(pick_id_s);
            grant_valid_s = 1'b1;
            grant_id_s    = pick_id_s;
         end else begin
            grant_s       = '0;
            grant_valid_s = 1'b0;
            grant_id_s    = '0;
         end
      end else begin
         grant_s       = grant;
         grant_valid_s = grant_valid;
         grant_id_s    = grant_id;
      end
   end

   // Registered grant outputs and arbitration state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant       <= '0;
         grant_valid <= 1'b0;
         grant_id    <= '0;
         ptr_r       <= '0;
         hold_cnt_r  <= '0;
      end else begin
         grant       <= grant_s;
         grant_valid <= grant_valid_s;
         grant_id    <= grant_id_s;
         ptr_r       <= ptr_s;
         hold_cnt_r  <= hold_cnt_s;
      end
   end

endmodule

// File: doc/arb_rr_n.md
Name: arb_rr_n

Overview:
- Parametrised N-requester arbiter; successor to the 2-requester port-based arbiter used by the arbiter testbenches.
- Adds a round-robin or fixed-priority mode select and a bounded grant hold (burst limit), so one requester cannot starve the others.
- Sits between N request sources and a shared resource.
- Grant is registered, one-hot, and also provided as an encoded index.

Parameters:
- N, 4: number of requesters; N >= 2.
- MAX_HOLD, 4: maximum consecutive cycles one owner keeps the grant while any other requester is waiting; MAX_HOLD >= 1.
- ID_W, $clog2(N): width of grant_id; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous active-high reset.
- request  input  N  request vector; bit i = requester i wants the resource.
- fixed_pri  input  1  0 = round-robin search; 1 = fixed priority, index 0 highest. Sampled every cycle.
- grant  output  N  registered one-hot grant, or all-zero.
- grant_valid  output  1  registered; equals |grant.
- grant_id  output  ID_W  registered index of the granted bit; 0 when grant_valid = 0.

Behaviour:
- Reset: rst high (asynchronous) forces the following immediately, with no clock edge needed:
  - grant = 0, grant_valid = 0, grant_id = 0;
  - ptr = 0 (round-robin search start);
  - hold_cnt = 0.
  - Requests are ignored while rst is high. First possible grant is at the first posedge after rst deasserts.
- State: IDLE (grant == 0) or OWN(k) (grant == 1<<k). ptr and hold_cnt are internal registers.
- Search function pick(start, mask):
  - Returns the first i with mask[i] = 1, scanning start, start+1, ... N-1, 0, ... with modulo-N wrap.
  - start = ptr in round-robin mode; start = 0 when fixed_pri = 1.
  - Returns "none" if mask == 0.
- IDLE transitions, at the posedge:
  - request != 0: go to OWN(pick(start, request)) and set hold_cnt = 0.
  - Otherwise stay in IDLE.
  - Latency: a request sampled at edge t is visible on grant just after edge t (one register stage).
- OWN(k) transitions, at the posedge:
  - request[k] = 0 (release): set ptr = (k+1) mod N. Then go to OWN(pick(new start, request)) with hold_cnt = 0, or to IDLE if no request. No idle bubble between owners.
  - request[k] = 1 and hold_cnt < MAX_HOLD-1: stay in OWN(k); hold_cnt++.
  - request[k] = 1, hold_cnt = MAX_HOLD-1, and (request & ~(1<<k)) != 0 (preempt):
    - set ptr = (k+1) mod N;
    - go to OWN(pick(new start, request & ~(1<<k)));
    - set hold_cnt = 0.
  - request[k] = 1, hold_cnt = MAX_HOLD-1, and no other request: stay in OWN(k); hold_cnt saturates at MAX_HOLD-1.
  - In fixed mode, the new start after a release or preempt is 0, not ptr. ptr is still updated so that round-robin resumes fairly.
- MAX_HOLD = 1: arbitration happens every cycle whenever another requester is present.
- Mode change: a fixed_pri change mid-grant takes effect at the next arbitration decision only. It never preempts the current owner early.
- Invariants (checkable by assertion):
  - grant is always one-hot or zero.
  - grant_valid == |grant.
  - grant_id == encode(grant).
  - grant[i] is never set at an edge where request[i] was 0.
- Width rules:
  - hold_cnt width is $clog2(MAX_HOLD), minimum 1.
  - ptr width is ID_W; wraps from N-1 to 0 (handles non-power-of-2 N).

Test Plan:
(All scenarios use N = 4, MAX_HOLD = 4.)
1. Reset: assert rst with request = 4'b1111 over 3 edges -> grant = 0000, grant_valid = 0, grant_id = 0 throughout. Deassert rst -> grant = 0001 after the next edge.
2. Single requester: request = 0100 for 3 edges, then 0000 -> grant = 0100, grant_id = 2 for 3 cycles, then 0000 after the following edge.
3. Round-robin fairness: fixed_pri = 0, request = 1111 held for 17 edges -> grant sequence is 0001 x4, 0010 x4, 0100 x4, 1000 x4, then 0001.
4. Early release and handover:
   - Stimulus: owner 1 holds for 2 cycles with request = 1011, then request[1] drops (request = 1001).
   - Required: grant goes 0010 -> 1000 on the same edge, with no bubble.
   - Then request[3] drops -> grant = 0001.
5. Fixed priority with preemption: fixed_pri = 1, request = 0111 -> grant = 0001 for 4 cycles, then 0010 (lowest other), then back to 0001 after 4 more cycles.
6. Async reset mid-grant: rst pulses between edges while grant = 1000 -> grant = 0000 immediately, before the next edge. After release with request = 0110 -> grant = 0010 (ptr was reset to 0).
